// File: rtl/me_frame_scheduler.sv
// Frame-level sequencer for the motion-estimation core.
// Walks the macroblocks of a frame in raster order, one MB in flight:
// window load -> me start -> me result capture -> tagged result out.
module me_frame_scheduler #(
    parameter int FRAME_W_MB = 11,
    parameter int FRAME_H_MB = 9,
    parameter int MV_W       = 6,
    parameter int SAD_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    output logic             busy,
    output logic             frame_done,
    output logic             win_load_req,
    input  logic             win_load_done,
    output logic [7:0]       mb_x,
    output logic [7:0]       mb_y,
    output logic             me_start,
    input  logic             me_readyi,
    input  logic             me_valido,
    output logic             me_readyo,
    input  logic [MV_W-1:0]  me_mv_x,
    input  logic [MV_W-1:0]  me_mv_y,
    input  logic [SAD_W-1:0] me_min_sad,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_mb_x,
    output logic [7:0]       res_mb_y,
    output logic [MV_W-1:0]  res_mv_x,
    output logic [MV_W-1:0]  res_mv_y,
    output logic [SAD_W-1:0] res_sad
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [7:0] X_LAST = 8'(FRAME_W_MB - 1);
    localparam logic [7:0] Y_LAST = 8'(FRAME_H_MB - 1);

    state_t           state_q, state_d;
    logic [7:0]       mb_x_q, mb_x_d;
    logic [7:0]       mb_y_q, mb_y_d;
    logic [7:0]       res_mb_x_q, res_mb_x_d;
    logic [7:0]       res_mb_y_q, res_mb_y_d;
    logic [MV_W-1:0]  res_mv_x_q, res_mv_x_d;
    logic [MV_W-1:0]  res_mv_y_q, res_mv_y_d;
    logic [SAD_W-1:0] res_sad_q, res_sad_d;

    // State, MB counters and the result holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mb_x_q     <= '0;
            mb_y_q     <= '0;
            res_mb_x_q <= '0;
            res_mb_y_q <= '0;
            res_mv_x_q <= '0;
            res_mv_y_q <= '0;
            res_sad_q  <= '0;
        end else begin
            state_q    <= state_d;
            mb_x_q     <= mb_x_d;
            mb_y_q     <= mb_y_d;
            res_mb_x_q <= res_mb_x_d;
            res_mb_y_q <= res_mb_y_d;
            res_mv_x_q <= res_mv_x_d;
            res_mv_y_q <= res_mv_y_d;
            res_sad_q  <= res_sad_d;
        end
    end

    // Next-state, raster counter advance and result capture.
    always_comb begin
        state_d    = state_q;
        mb_x_d     = mb_x_q;
        mb_y_d     = mb_y_q;
        res_mb_x_d = res_mb_x_q;
        res_mb_y_d = res_mb_y_q;
        res_mv_x_d = res_mv_x_q;
        res_mv_y_d = res_mv_y_q;
        res_sad_d  = res_sad_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_LOAD;
                    mb_x_d  = '0;
                    mb_y_d  = '0;
                end
            end
            S_LOAD: begin
                if (win_load_done) state_d = S_START;
            end
            S_START: begin
                // me_valido here is deliberately ignored; results are only taken in WAIT.
                if (me_readyi) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (me_valido) begin
                    state_d    = S_OUT;
                    res_mb_x_d = mb_x_q;
                    res_mb_y_d = mb_y_q;
                    res_mv_x_d = me_mv_x;
                    res_mv_y_d = me_mv_y;
                    res_sad_d  = me_min_sad;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    if (mb_x_q == X_LAST && mb_y_q == Y_LAST) begin
                        // Last MB: park counters at 0 rather than stepping past the frame.
                        state_d = S_DONE;
                        mb_x_d  = '0;
                        mb_y_d  = '0;
                    end else if (mb_x_q == X_LAST) begin
                        state_d = S_LOAD;
                        mb_x_d  = '0;
                        mb_y_d  = mb_y_q + 8'd1;
                    end else begin
                        state_d = S_LOAD;
                        mb_x_d  = mb_x_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                mb_x_d  = '0;
                mb_y_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from the registered state only.
    always_comb begin
        busy         = (state_q != S_IDLE);
        frame_done   = (state_q == S_DONE);
        win_load_req = (state_q == S_LOAD);
        me_start     = (state_q == S_START);
        me_readyo    = (state_q == S_WAIT);
        res_valid    = (state_q == S_OUT);
        mb_x         = mb_x_q;
        mb_y         = mb_y_q;
        res_mb_x     = res_mb_x_q;
        res_mb_y     = res_mb_y_q;
        res_mv_x     = res_mv_x_q;
        res_mv_y     = res_mv_y_q;
        res_sad      = res_sad_q;
    end

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Bench for me_frame_scheduler: a 3x2-MB instance driven with randomized
// loader/me/downstream timing and checked through a result scoreboard,
// plus a 1x1-MB instance for the single-MB frame.
module tb_me_frame_scheduler;

    localparam int W = 3;
    localparam int H = 2;
    localparam int N = W * H;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [5:0]  mvx;
        logic [5:0]  mvy;
        logic [15:0] sad;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // main instance
    logic        frame_start = 1'b0, win_load_done = 1'b0, me_readyi = 1'b0, me_valido = 1'b0, res_ready = 1'b0;
    logic [5:0]  me_mv_x = '0, me_mv_y = '0;
    logic [15:0] me_min_sad = '0;
    logic        busy, frame_done, win_load_req, me_start, me_readyo, res_valid;
    logic [7:0]  mb_x, mb_y, res_mb_x, res_mb_y;
    logic [5:0]  res_mv_x, res_mv_y;
    logic [15:0] res_sad;

    // 1x1 instance
    logic        s_frame_start = 1'b0, s_win_load_done = 1'b0, s_me_readyi = 1'b0, s_me_valido = 1'b0, s_res_ready = 1'b0;
    logic [5:0]  s_me_mv_x = '0, s_me_mv_y = '0;
    logic [15:0] s_me_min_sad = '0;
    logic        s_busy, s_frame_done, s_win_load_req, s_me_start, s_me_readyo, s_res_valid;
    logic [7:0]  s_mb_x, s_mb_y, s_res_mb_x, s_res_mb_y;
    logic [5:0]  s_res_mv_x, s_res_mv_y;
    logic [15:0] s_res_sad;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_xfer = 0;
    int   n_done = 0;
    int   stall_n = 0;

    me_frame_scheduler #(.FRAME_W_MB(W), .FRAME_H_MB(H), .MV_W(6), .SAD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
        .win_load_req(win_load_req), .win_load_done(win_load_done), .mb_x(mb_x), .mb_y(mb_y),
        .me_start(me_start), .me_readyi(me_readyi), .me_valido(me_valido), .me_readyo(me_readyo),
        .me_mv_x(me_mv_x), .me_mv_y(me_mv_y), .me_min_sad(me_min_sad),
        .res_valid(res_valid), .res_ready(res_ready), .res_mb_x(res_mb_x), .res_mb_y(res_mb_y),
        .res_mv_x(res_mv_x), .res_mv_y(res_mv_y), .res_sad(res_sad)
    );

    me_frame_scheduler #(.FRAME_W_MB(1), .FRAME_H_MB(1), .MV_W(6), .SAD_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(s_frame_start), .busy(s_busy), .frame_done(s_frame_done),
        .win_load_req(s_win_load_req), .win_load_done(s_win_load_done), .mb_x(s_mb_x), .mb_y(s_mb_y),
        .me_start(s_me_start), .me_readyi(s_me_readyi), .me_valido(s_me_valido), .me_readyo(s_me_readyo),
        .me_mv_x(s_me_mv_x), .me_mv_y(s_me_mv_y), .me_min_sad(s_me_min_sad),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_mb_x(s_res_mb_x), .res_mb_y(s_res_mb_y),
        .res_mv_x(s_res_mv_x), .res_mv_y(s_res_mv_y), .res_sad(s_res_sad)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: random, with a forced low window when stall_n is loaded.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (stall_n > 0) begin
                res_ready = 1'b0;
                stall_n--;
            end else begin
                res_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Scoreboard monitor: every presented result must match the oldest expected
    // entry (which also proves it is stable while stalled); pop on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                chk_eq("no_load_in_out", win_load_req, 1'b0);
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_result", res_valid, 1'b0);
                end else begin
                    chk_eq("res_data", {res_mb_x, res_mb_y, res_mv_x, res_mv_y, res_sad},
                           {exp_q[0].x, exp_q[0].y, exp_q[0].mvx, exp_q[0].mvy, exp_q[0].sad});
                    chk_eq("cur_mb_held", {mb_x, mb_y}, {exp_q[0].x, exp_q[0].y});
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        n_xfer++;
                    end
                end
            end
            if (frame_done) n_done++;
        end
    end

    task automatic start_frame();
        n_xfer = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk_eq("frame_begin", {busy, win_load_req, mb_x, mb_y}, {2'b11, 16'h0});
    endtask

    // Plays loader and me for one MB; with abort set it stops once WAIT is reached.
    task automatic run_mb(input int idx, input bit fs_in_wait, input bit stall, input int rdy_low, input bit abort);
        int   n;
        int   r;
        res_t e;
        n = 0;
        while (!win_load_req && n < 200) begin
            tick();
            n++;
        end
        chk_eq("load_req_seen", win_load_req, 1'b1);
        chk_eq("load_coord", {mb_x, mb_y}, {8'(idx % W), 8'(idx / W)});
        r = $urandom_range(0, 3);
        repeat (r) tick();
        win_load_done = 1'b1;
        tick();
        win_load_done = 1'b0;
        chk_eq("start_after_load", {me_start, win_load_req}, 2'b10);
        r = (rdy_low >= 0) ? rdy_low : $urandom_range(0, 2);
        repeat (r) begin
            tick();
            chk_eq("start_held", me_start, 1'b1);
        end
        me_readyi  = 1'b1;
        me_valido  = 1'($urandom_range(0, 1));
        me_mv_x    = 6'($urandom);
        me_mv_y    = 6'($urandom);
        me_min_sad = 16'($urandom);
        tick();
        me_readyi = 1'b0;
        me_valido = 1'b0;
        chk_eq("wait_entered", {me_start, me_readyo, res_valid}, 3'b010);
        if (abort) return;
        if (fs_in_wait) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            chk_eq("fs_ignored", {me_readyo, mb_x, mb_y}, {1'b1, 8'(idx % W), 8'(idx / W)});
        end
        r = $urandom_range(0, 10);
        repeat (r) begin
            tick();
            chk_eq("no_early_result", res_valid, 1'b0);
        end
        me_valido  = 1'b1;
        me_mv_x    = 6'($urandom);
        me_mv_y    = 6'($urandom);
        me_min_sad = 16'($urandom);
        e.x   = 8'(idx % W);
        e.y   = 8'(idx / W);
        e.mvx = me_mv_x;
        e.mvy = me_mv_y;
        e.sad = me_min_sad;
        exp_q.push_back(e);
        if (stall) stall_n = 6;
        tick();
        me_valido = 1'b0;
        chk_eq("res_latency", {res_valid, me_readyo}, 2'b10);
    endtask

    task automatic run_frame(input bit directed);
        int n;
        start_frame();
        for (int i = 0; i < N; i++)
            run_mb(i, directed && i == 1, directed && i == 0, (directed && i == 2) ? 4 : -1, 1'b0);
        n = 0;
        while (!frame_done && n < 200) begin
            tick();
            n++;
        end
        chk_eq("frame_done_pulse", frame_done, 1'b1);
        chk_eq("results_per_frame", n_xfer, N);
        chk_eq("done_counters", {busy, mb_x, mb_y}, {1'b1, 16'h0});
        tick();
        chk_eq("idle_after_done", {frame_done, busy}, 2'b00);
    endtask

    initial begin
        #1;
        chk_eq("rst_ctrl", {busy, frame_done, win_load_req, me_start, me_readyo, res_valid}, 6'h0);
        chk_eq("rst_data", {mb_x, mb_y, res_mb_x, res_mb_y, res_mv_x, res_mv_y, res_sad}, 60'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        // inputs other than frame_start are ignored in IDLE
        win_load_done = 1'b1;
        me_valido     = 1'b1;
        tick();
        win_load_done = 1'b0;
        me_valido     = 1'b0;
        chk_eq("idle_ignores", {busy, res_valid}, 2'b00);

        run_frame(1'b1);
        run_frame(1'b0);

        // reset while waiting for me: everything clears at once, no partial result
        start_frame();
        run_mb(0, 1'b0, 1'b0, -1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_eq("midrst_ctrl", {busy, frame_done, win_load_req, me_start, me_readyo, res_valid}, 6'h0);
        chk_eq("midrst_data", {mb_x, mb_y, res_mb_x, res_mb_y, res_mv_x, res_mv_y, res_sad}, 60'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_frame(1'b0);

        chk_eq("frames_done", n_done, 3);
        chk_eq("queue_drained", exp_q.size(), 0);

        // 1x1 frame
        s_frame_start = 1'b1;
        tick();
        s_frame_start = 1'b0;
        chk_eq("s_load", {s_win_load_req, s_mb_x, s_mb_y}, {1'b1, 16'h0});
        s_win_load_done = 1'b1;
        tick();
        s_win_load_done = 1'b0;
        chk_eq("s_start", s_me_start, 1'b1);
        s_me_readyi = 1'b1;
        tick();
        s_me_readyi  = 1'b0;
        s_me_valido  = 1'b1;
        s_me_mv_x    = 6'h2a;
        s_me_mv_y    = 6'h15;
        s_me_min_sad = 16'hbeef;
        tick();
        s_me_valido = 1'b0;
        chk_eq("s_result", {s_res_valid, s_res_mb_x, s_res_mb_y, s_res_mv_x, s_res_mv_y, s_res_sad},
               {1'b1, 8'h0, 8'h0, 6'h2a, 6'h15, 16'hbeef});
        tick();
        chk_eq("s_held", {s_res_valid, s_frame_done}, 2'b10);
        s_res_ready = 1'b1;
        tick();
        s_res_ready = 1'b0;
        chk_eq("s_done", {s_frame_done, s_res_valid, s_mb_x, s_mb_y}, {2'b10, 16'h0});
        tick();
        chk_eq("s_idle", {s_frame_done, s_busy}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
